// File: rtl/decode_stage.sv
// decode_stage: RV32I decoder feeding register_manager through a 2-entry (OUT + SKID) buffer.
// Define DECODE_ILLEGAL_TRAP_EN to trap illegal instructions instead of issuing them as NOPs.

package cpu_parameters;
  localparam int xlen = 32;
endpackage

module decode_stage
  import cpu_parameters::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     instr_i,
  input  logic [xlen-1:0] pc_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [15:0]     decode_o,
  output logic [24:0]     instruction_o,
  output logic [xlen-1:0] pc_o,
  output logic [xlen-1:0] jal_res_o,
  output logic            valid_o,
  input  logic            ok_i,
  input  logic            flush
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,
  output logic            illegal_o,
  output logic [xlen-1:0] illegal_pc_o
`endif
);

  localparam logic [15:0]     NOP_CODE = 16'hC000;
  localparam logic [xlen-1:0] PC_STEP  = {{(xlen-3){1'b0}}, 3'd4};

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [1:0]      unit;
  logic [2:0]      sub_unit;
  logic [3:0]      sel;
  logic            imm;
  logic            j_instr;
  logic            legal;
  logic            is_nop;
  logic [15:0]     dec_word;
  logic [xlen-1:0] link_in;

  logic [15:0]     skid_dec;
  logic [24:0]     skid_instr;
  logic [xlen-1:0] skid_pc;
  logic [xlen-1:0] skid_link;

  logic in_acc;
  logic out_acc;
  logic push;

  always_comb begin
    opcode   = instr_i[6:0];
    funct3   = instr_i[14:12];
    funct7   = instr_i[31:25];
    unit     = 2'd0;
    sub_unit = 3'd0;
    sel      = {1'b0, funct3};
    imm      = 1'b0;
    j_instr  = 1'b0;
    legal    = 1'b1;
    is_nop   = 1'b0;
    case (opcode)
      OP_LUI: begin
        sel = 4'd0;
        imm = 1'b1;
      end
      OP_AUIPC: begin
        sel = 4'd1;
        imm = 1'b1;
      end
      OP_JAL: begin
        sel     = 4'd2;
        imm     = 1'b1;
        j_instr = 1'b1;
      end
      OP_JALR: begin
        sel     = 4'd3;
        imm     = 1'b1;
        j_instr = 1'b1;
        legal   = (funct3 == 3'd0);
      end
      OP_BRANCH: begin
        sub_unit = 3'd1;
        imm      = 1'b1;
        j_instr  = 1'b1;
        legal    = (funct3[2:1] != 2'b01);
      end
      OP_LOAD: begin
        unit  = 2'd1;
        imm   = 1'b1;
        legal = funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      end
      OP_STORE: begin
        unit     = 2'd1;
        sub_unit = 3'd1;
        imm      = 1'b1;
        legal    = funct3 inside {3'd0, 3'd1, 3'd2};
      end
      // Only SRAI keeps funct7[5] in the select; other immediates would alias into SUB/SRA codes.
      OP_IMM: begin
        sub_unit = 3'd2;
        imm      = 1'b1;
        if (funct3 == 3'd1) begin
          legal = (funct7 == 7'h00);
        end else if (funct3 == 3'd5) begin
          legal = (funct7 == 7'h00) || (funct7 == 7'h20);
          sel   = {funct7[5], funct3};
        end
      end
      OP_REG: begin
        sub_unit = 3'd2;
        sel      = {funct7[5], funct3};
        legal    = (funct7 == 7'h00) ||
                   ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5)));
      end
      OP_FENCE, OP_SYSTEM: begin
        is_nop = 1'b1;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
    dec_word = (legal && !is_nop) ? {unit, sub_unit, sel, imm, 5'b00000, j_instr} : NOP_CODE;
  end

  assign link_in = pc_i + PC_STEP;
  assign valid_o = (state != EMPTY);
  assign in_acc  = valid_i && ready_o;
  assign out_acc = valid_o && ok_i;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic halted;
  assign ready_o = (state != FULL) && !halted;
  assign push    = in_acc && legal;
`else
  assign ready_o = (state != FULL);
  assign push    = in_acc;
`endif

  // OUT registers drive the ports directly; decode_o is parked on the NOP code whenever OUT is empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= EMPTY;
      decode_o      <= NOP_CODE;
      instruction_o <= '0;
      pc_o          <= '0;
      jal_res_o     <= '0;
      skid_dec      <= NOP_CODE;
      skid_instr    <= '0;
      skid_pc       <= '0;
      skid_link     <= '0;
`ifdef DECODE_ILLEGAL_TRAP_EN
      halted        <= 1'b0;
      illegal_o     <= 1'b0;
      illegal_pc_o  <= '0;
`endif
    end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      illegal_o <= 1'b0;
`endif
      if (flush) begin
        state    <= EMPTY;
        decode_o <= NOP_CODE;
`ifdef DECODE_ILLEGAL_TRAP_EN
        halted   <= 1'b0;
`endif
      end else begin
`ifdef DECODE_ILLEGAL_TRAP_EN
        if (in_acc && !legal) begin
          illegal_o    <= 1'b1;
          illegal_pc_o <= pc_i;
          halted       <= 1'b1;
        end
`endif
        case (state)
          EMPTY: begin
            if (push) begin
              decode_o      <= dec_word;
              instruction_o <= instr_i[31:7];
              pc_o          <= pc_i;
              jal_res_o     <= link_in;
              state         <= ONE;
            end
          end
          ONE: begin
            if (push && out_acc) begin
              decode_o      <= dec_word;
              instruction_o <= instr_i[31:7];
              pc_o          <= pc_i;
              jal_res_o     <= link_in;
            end else if (push) begin
              skid_dec   <= dec_word;
              skid_instr <= instr_i[31:7];
              skid_pc    <= pc_i;
              skid_link  <= link_in;
              state      <= FULL;
            end else if (out_acc) begin
              decode_o <= NOP_CODE;
              state    <= EMPTY;
            end
          end
          FULL: begin
            if (out_acc) begin
              decode_o      <= skid_dec;
              instruction_o <= skid_instr;
              pc_o          <= skid_pc;
              jal_res_o     <= skid_link;
              state         <= ONE;
            end
          end
          default: begin
            state    <= EMPTY;
            decode_o <= NOP_CODE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a queue-based reference model.
// Illegal-instruction expectations follow DECODE_ILLEGAL_TRAP_EN when it is defined.
module tb_decode_stage;
  localparam int XLEN = cpu_parameters::xlen;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [31:0]     instr_i;
  logic [XLEN-1:0] pc_i;
  logic            valid_i;
  logic            ready_o;
  logic [15:0]     decode_o;
  logic [24:0]     instruction_o;
  logic [XLEN-1:0] pc_o;
  logic [XLEN-1:0] jal_res_o;
  logic            valid_o;
  logic            ok_i;
  logic            flush;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic            illegal_o;
  logic [XLEN-1:0] illegal_pc_o;
`endif

  typedef struct {
    logic [15:0]     dec;
    logic [24:0]     ins;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t          model_q[$];
  bit              model_halted;
  bit              exp_illegal;
  logic [XLEN-1:0] exp_illegal_pc;
  int              illegal_issued = 0;
  int              vectors = 0;
  int              miscompares = 0;

  localparam logic [31:0] TBL_INSTR [12] = '{
    32'h00510093, 32'h000000EF, 32'h00000063, 32'h00002003, 32'h00002023, 32'h40000033,
    32'h000000B7, 32'h00000097, 32'h000080E7, 32'h4020D093, 32'h0000000F, 32'h00000073};
  localparam logic [15:0] TBL_DEC [12] = '{
    16'h1040, 16'h0141, 16'h0841, 16'h4140, 16'h4940, 16'h1400,
    16'h0040, 16'h00C0, 16'h01C1, 16'h16C0, 16'hC000, 16'hC000};
  localparam logic [6:0] OPCODES [11] = '{
    7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};

  decode_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_i       (instr_i),
    .pc_i          (pc_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .decode_o      (decode_o),
    .instruction_o (instruction_o),
    .pc_o          (pc_o),
    .jal_res_o     (jal_res_o),
    .valid_o       (valid_o),
    .ok_i          (ok_i),
    .flush         (flush)
`ifdef DECODE_ILLEGAL_TRAP_EN
    ,
    .illegal_o     (illegal_o),
    .illegal_pc_o  (illegal_pc_o)
`endif
  );

  always #5 clk = ~clk;

  // Reference decode built from the field rules as plain arithmetic on unit/sub/sel weights.
  function automatic logic [15:0] ref_decode(input logic [31:0] w, output bit legal);
    int f3, f7, unit, sub, sel, imm, j;
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    legal = 1; unit = 0; sub = 0; sel = 0; imm = 1; j = 0;
    case (w[6:0])
      7'h37: sel = 0;
      7'h17: sel = 1;
      7'h6F: begin sel = 2; j = 1; end
      7'h67: begin sel = 3; j = 1; legal = (f3 == 0); end
      7'h63: begin sub = 1; sel = f3; j = 1; legal = (f3 != 2 && f3 != 3); end
      7'h03: begin unit = 1; sel = f3; legal = (f3 <= 2 || f3 == 4 || f3 == 5); end
      7'h23: begin unit = 1; sub = 1; sel = f3; legal = (f3 <= 2); end
      7'h13: begin
        sub = 2; sel = f3;
        if (f3 == 1) legal = (f7 == 0);
        if (f3 == 5) begin
          legal = (f7 == 0 || f7 == 32);
          if (f7 == 32) sel = 8 + f3;
        end
      end
      7'h33: begin
        sub = 2; imm = 0; sel = ((f7 == 32) ? 8 : 0) + f3;
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
      end
      7'h0F, 7'h73: return 16'hC000;
      default: legal = 0;
    endcase
    if (!legal) return 16'hC000;
    return 16'(unit * 16384 + sub * 2048 + sel * 128 + imm * 64 + j);
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 3) != 0) w[6:0] = OPCODES[$urandom_range(0, 10)];
    if ($urandom_range(0, 1) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic apply_stimulus(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                                input logic ok, input logic fl);
    valid_i = v;
    instr_i = ins;
    pc_i    = pc;
    ok_i    = ok;
    flush   = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, '0, 1'b0, 1'b0);
    tick(); tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", valid_o); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ready: got %b, expected 1", ready_o); end
    vectors++; if (decode_o !== 16'hC000) begin miscompares++; $display("[TB] FAIL reset_decode: got %h, expected c000", decode_o); end
    vectors++;
    if (instruction_o !== 25'h0 || pc_o !== '0 || jal_res_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_fields: got instr %h pc %h link %h, expected all 0", instruction_o, pc_o, jal_res_o);
    end
`ifdef DECODE_ILLEGAL_TRAP_EN
    vectors++; if (illegal_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_illegal: got %b, expected 0", illegal_o); end
`endif
    rst_n = 1'b1;
    apply_stimulus(1'b1, 32'h00510093, 32'h80, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h40000033, 32'h84, 1'b0, 1'b0);
    tick();
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL prereset_full: ready got %b, expected 0", ready_o); end
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, '0, 1'b0, 1'b0);
    tick();
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || decode_o !== 16'hC000 || pc_o !== '0) begin
      miscompares++;
      $display("[TB] FAIL midreset: got valid %b ready %b dec %h pc %h, expected 0 1 c000 0", valid_o, ready_o, decode_o, pc_o);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_decode_table();
    logic [31:0]     cur;
    logic [XLEN-1:0] pc;
    for (int i = 0; i < 12; i++) begin
      cur = TBL_INSTR[i];
      pc  = 32'h100 + 32'(4 * i);
      apply_stimulus(1'b1, cur, pc, 1'b1, 1'b0);
      tick();
      vectors++;
      if (valid_o !== 1'b1 || decode_o !== TBL_DEC[i] || ready_o !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL table_decode[%0d]: got valid %b dec %h ready %b, expected 1 %h 1", i, valid_o, decode_o, ready_o, TBL_DEC[i]);
      end
      vectors++;
      if (instruction_o !== cur[31:7] || pc_o !== pc || jal_res_o !== pc + 32'h4) begin
        miscompares++;
        $display("[TB] FAIL table_fields[%0d]: got instr %h pc %h link %h, expected %h %h %h", i, instruction_o, pc_o, jal_res_o, cur[31:7], pc, pc + 32'h4);
      end
    end
    apply_stimulus(1'b0, 32'h0, '0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (valid_o !== 1'b0 || decode_o !== 16'hC000) begin
      miscompares++;
      $display("[TB] FAIL table_drain: got valid %b dec %h, expected 0 c000", valid_o, decode_o);
    end
  endtask

  task automatic test_back_to_back();
    apply_stimulus(1'b1, 32'h00510093, 32'h200, 1'b0, 1'b0);
    tick();
    vectors++; if (ready_o !== 1'b1 || pc_o !== 32'h200) begin miscompares++; $display("[TB] FAIL b2b_one: got ready %b pc %h, expected 1 200", ready_o, pc_o); end
    apply_stimulus(1'b1, 32'h40000033, 32'h204, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ready_o !== 1'b0 || pc_o !== 32'h200 || decode_o !== 16'h1040) begin
      miscompares++;
      $display("[TB] FAIL b2b_full: got ready %b pc %h dec %h, expected 0 200 1040", ready_o, pc_o, decode_o);
    end
    apply_stimulus(1'b1, 32'h00002003, 32'h208, 1'b0, 1'b0);
    tick();
    vectors++;
    if (ready_o !== 1'b0 || pc_o !== 32'h200 || instruction_o !== 25'h000A201) begin
      miscompares++;
      $display("[TB] FAIL b2b_hold: got ready %b pc %h instr %h, expected 0 200 000a201", ready_o, pc_o, instruction_o);
    end
    apply_stimulus(1'b0, 32'h0, '0, 1'b1, 1'b0);
    tick();
    vectors++;
    if (valid_o !== 1'b1 || pc_o !== 32'h204 || decode_o !== 16'h1400 || ready_o !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL b2b_second: got valid %b pc %h dec %h ready %b, expected 1 204 1400 1", valid_o, pc_o, decode_o, ready_o);
    end
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_empty: got valid %b, expected 0", valid_o); end
  endtask

  task automatic test_flush();
    apply_stimulus(1'b1, 32'h00510093, 32'h300, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h00002023, 32'h304, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b1, 32'h000000EF, 32'h308, 1'b0, 1'b1);
    tick();
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || decode_o !== 16'hC000) begin
      miscompares++;
      $display("[TB] FAIL flush_full: got valid %b ready %b dec %h, expected 0 1 c000", valid_o, ready_o, decode_o);
    end
    apply_stimulus(1'b0, 32'h0, '0, 1'b0, 1'b0);
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_lost: got valid %b, expected 0", valid_o); end
  endtask

  task automatic test_pc_wrap();
    apply_stimulus(1'b1, 32'h00510093, 32'hFFFFFFFC, 1'b1, 1'b0);
    tick();
    vectors++;
    if (jal_res_o !== 32'h0 || pc_o !== 32'hFFFFFFFC) begin
      miscompares++;
      $display("[TB] FAIL pc_wrap: got pc %h link %h, expected fffffffc 00000000", pc_o, jal_res_o);
    end
    apply_stimulus(1'b0, 32'h0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_illegal();
    apply_stimulus(1'b1, 32'hFFFFFFFF, 32'h400, 1'b1, 1'b0);
    tick();
`ifdef DECODE_ILLEGAL_TRAP_EN
    vectors++;
    if (illegal_o !== 1'b1 || illegal_pc_o !== 32'h400 || valid_o !== 1'b0 || ready_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_trap: got pulse %b pc %h valid %b ready %b, expected 1 400 0 0", illegal_o, illegal_pc_o, valid_o, ready_o);
    end
    apply_stimulus(1'b1, 32'h00510093, 32'h404, 1'b1, 1'b0);
    tick();
    vectors++;
    if (illegal_o !== 1'b0 || ready_o !== 1'b0 || valid_o !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_stall: got pulse %b ready %b valid %b, expected 0 0 0", illegal_o, ready_o, valid_o);
    end
    apply_stimulus(1'b0, 32'h0, '0, 1'b1, 1'b1);
    tick();
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("[TB] FAIL illegal_release: got ready %b, expected 1", ready_o); end
`else
    vectors++;
    if (decode_o !== 16'hC000 || valid_o !== 1'b1 || pc_o !== 32'h400) begin
      miscompares++;
      $display("[TB] FAIL illegal_nop: got dec %h valid %b pc %h, expected c000 1 400", decode_o, valid_o, pc_o);
    end
`endif
    apply_stimulus(1'b0, 32'h0, '0, 1'b1, 1'b0);
    tick();
    vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL illegal_after: got valid %b, expected 0", valid_o); end
  endtask

  task automatic test_random();
    entry_t          e;
    bit              lg, exp_ready, in_acc, out_acc;
    logic [XLEN-1:0] exp_link;
    rst_n = 1'b0;
    apply_stimulus(1'b0, 32'h0, '0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    model_q.delete();
    model_halted = 0;
    exp_illegal  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      exp_ready = (model_q.size() < 2) && !model_halted;
      if (model_q.size() != 0) begin
        exp_link = model_q[0].pc + 32'h4;
        vectors++;
        if (valid_o !== 1'b1 || decode_o !== model_q[0].dec) begin
          miscompares++;
          $display("[TB] FAIL rand_decode @%0d: got valid %b dec %h, expected 1 %h", cyc, valid_o, decode_o, model_q[0].dec);
        end
        vectors++;
        if (instruction_o !== model_q[0].ins || pc_o !== model_q[0].pc || jal_res_o !== exp_link) begin
          miscompares++;
          $display("[TB] FAIL rand_fields @%0d: got instr %h pc %h link %h, expected %h %h %h", cyc, instruction_o, pc_o, jal_res_o, model_q[0].ins, model_q[0].pc, exp_link);
        end
      end else begin
        vectors++;
        if (valid_o !== 1'b0 || decode_o !== 16'hC000) begin
          miscompares++;
          $display("[TB] FAIL rand_empty @%0d: got valid %b dec %h, expected 0 c000", cyc, valid_o, decode_o);
        end
      end
      vectors++;
      if (ready_o !== exp_ready) begin
        miscompares++;
        $display("[TB] FAIL rand_ready @%0d: got %b, expected %b", cyc, ready_o, exp_ready);
      end
`ifdef DECODE_ILLEGAL_TRAP_EN
      vectors++;
      if (illegal_o !== exp_illegal || (exp_illegal && illegal_pc_o !== exp_illegal_pc)) begin
        miscompares++;
        $display("[TB] FAIL rand_illegal @%0d: got %b pc %h, expected %b pc %h", cyc, illegal_o, illegal_pc_o, exp_illegal, exp_illegal_pc);
      end
`endif
      apply_stimulus($urandom_range(0, 3) != 0, gen_instr(),
                     ($urandom_range(0, 19) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC),
                     $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
      in_acc      = valid_i && exp_ready;
      out_acc     = (model_q.size() != 0) && ok_i;
      exp_illegal = 0;
      if (flush) begin
        model_q.delete();
        model_halted = 0;
      end else begin
        if (out_acc) void'(model_q.pop_front());
        if (in_acc) begin
          e.dec = ref_decode(instr_i, lg);
          e.ins = instr_i[31:7];
          e.pc  = pc_i;
`ifdef DECODE_ILLEGAL_TRAP_EN
          if (!lg) begin
            model_halted   = 1;
            exp_illegal    = 1;
            exp_illegal_pc = pc_i;
          end else begin
            model_q.push_back(e);
          end
`else
          if (!lg) illegal_issued++;
          model_q.push_back(e);
`endif
        end
      end
      tick();
    end
    $display("[TB] random run issued %0d illegal words as bubbles", illegal_issued);
  endtask

  initial begin
    test_reset();
    test_decode_table();
    test_back_to_back();
    test_flush();
    test_pc_wrap();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage, sitting between instruction fetch and `register_manager`. It accepts raw 32-bit RV32I instructions with their PC over a valid/ready handshake and produces the 16-bit decode word, the 25-bit instruction field (`instr[31:7]`), the PC and the link value (PC+4). All of these are registered and buffered through a 2-entry skid buffer, so fetch sees full throughput while `register_manager` back-pressures through its `ok_o`.

## Interface
- Parameters: none local; `xlen` comes from `cpu_parameters`.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `instr_i` in 32: raw instruction from fetch.
- `pc_i` in xlen: PC of `instr_i`.
- `valid_i` in 1: `instr_i`/`pc_i` valid.
- `ready_o` out 1: stage can accept an instruction.
- `decode_o` out 16: decode word, feeds `register_manager.decode`.
- `instruction_o` out 25: `instr[31:7]`.
- `pc_o` out xlen: PC of the output instruction.
- `jal_res_o` out xlen: `pc + 4`.
- `valid_o` out 1: output entry valid.
- `ok_i` in 1: downstream accepted; driven by `register_manager.ok_o`.
- `flush` in 1: drop all buffered entries.
- `illegal_o` out 1: illegal-instruction pulse. Present only with `DECODE_ILLEGAL_TRAP_EN`.
- `illegal_pc_o` out xlen: PC of the illegal instruction. Present only with `DECODE_ILLEGAL_TRAP_EN`.

## Operation
- Decode word fields:
  - [15:14] unit, [13:11] sub_unit, [10:7] sel.
  - [6] imm: set for I/S/B/U/J formats.
  - [5:1] zero.
  - [0] j_instr: set for JAL, JALR and branches.
- ALU decodes (unit 0):
  - LUI: sub 0, sel 0.
  - AUIPC: sub 0, sel 1.
  - JAL: sub 0, sel 2.
  - JALR: sub 0, sel 3.
  - Branch: sub 1, sel = funct3.
  - OP/OP-IMM: sub 2, sel = {funct7[5], funct3}. funct7[5] is forced to 0 for OP-IMM, except SRAI.
- LSU decodes (unit 1):
  - Load: sub 0, sel = {0, funct3}.
  - Store: sub 1, sel = {0, funct3}.
- Unit 3, sub 0, sel 0 (16'hC000) is the NOP/bubble code. `decode_o` reads 16'hC000 whenever `valid_o`=0.
- Illegal instructions:
  - Any unrecognised opcode, funct3 or funct7 is illegal.
  - FENCE and SYSTEM are treated as NOP (16'hC000, valid).
- Buffer structure: two entries, OUT (drives outputs) and SKID. Each entry holds the decode word, instruction, PC and PC+4, decoded combinationally at input.
- States and transitions:
  - States: EMPTY, ONE (OUT only), FULL (OUT+SKID).
  - `ready_o` = !FULL.
  - Input accept = `valid_i && ready_o`. Output accept = `valid_o && ok_i`.
  - EMPTY + in → ONE.
  - ONE + in, no out → FULL (new entry goes to SKID).
  - ONE + in + out → ONE (OUT replaced).
  - ONE + out → EMPTY.
  - FULL + out → ONE (SKID moves to OUT).
- `flush`: next state EMPTY, and any input presented that cycle is discarded. Flush takes priority over all other events.
- PC+4 arithmetic is modulo 2^xlen; wrap is silent.

## Timing
- Latency: instruction accepted at cycle N appears on outputs at N+1.
- Throughput: 1 per cycle while `ok_i` is held high.
- `ready_o` depends only on registered state; no combinational path from `ok_i`.
- Reset values (synchronous reset, applied on the edge while `rst_n`=0):
  - State EMPTY, `valid_o`=0, `ready_o`=1.
  - `decode_o`=16'hC000.
  - `instruction_o`, `pc_o`, `jal_res_o` = 0.
  - `illegal_o`=0.
- Reset mid-operation drops all entries.
- Outputs are stable while `valid_o`=1 and `ok_i`=0.

## Configuration
- Macro: `DECODE_ILLEGAL_TRAP_EN`.
- Defined:
  - An illegal instruction is not enqueued.
  - `illegal_o` pulses for 1 cycle, one cycle after acceptance, with `illegal_pc_o` = its PC.
  - `ready_o` drops to 0 and stays low until `flush`.
- Undefined:
  - An illegal instruction is enqueued as NOP 16'hC000 with its PC.
  - `illegal_o` and `illegal_pc_o` ports are absent.

## Test plan
- ADDI x1,x2,5 (0x00510093), pc 0x100, `ok_i`=1 → next cycle `decode_o`=16'h1040, `instruction_o`=25'h000A201, `jal_res_o`=0x104, `valid_o`=1.
- JAL x1,0 (0x000000EF) → 16'h0141. BEQ (0x00000063) → 16'h0841. LW (0x00002003) → 16'h4140. SW (0x00002023) → 16'h4940. SUB (0x40000033) → 16'h1400.
- Back-to-back stream with `ok_i`=0: after 2 accepts `ready_o`=0 and outputs hold the first entry. Raise `ok_i` → entries drain in order, one per cycle.
- FULL state plus `flush` with `valid_i`=1 → next cycle `valid_o`=0, `ready_o`=1, `decode_o`=16'hC000, and the presented input is lost.
- pc 0xFFFFFFFC (xlen=32) → `jal_res_o`=0x00000000.
- Illegal word 0xFFFFFFFF: with the macro → `illegal_o` pulse, `illegal_pc_o`=pc, `ready_o` stays 0 until `flush`. Without the macro → `decode_o`=16'hC000, `valid_o`=1.
